mfm_decoder: RTL and testbench

//  Downstream consumer of the MFM_Shift cell stream. Samples one MFM cell per

---
 rtl/mfm_pkg.sv | 16 +
 rtl/mfm_clock_check.sv | 38 +++
 rtl/mfm_decoder.sv | 123 ++++++++++++
 tb/tb_mfm_decoder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mfm_pkg.sv
// Shared constants and types for the MFM byte decoder.
package mfm_pkg;

  // Cell pattern of the A1 sync mark (A1 data with one clock cell missing).
  localparam logic [15:0] SYNC_WORD_DEF = 16'h4489;

  // Data value reported for a sync mark.
  localparam logic [7:0] MARK_BYTE = 8'hA1;

  // Framing state: searching for a sync mark, or slicing aligned bytes.
  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/mfm_clock_check.sv
// Combinational slicer for one 16-cell window: extracts the data byte,
// flags the sync mark and checks every clock cell against the MFM rule.
module mfm_clock_check
  import mfm_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF
) (
  input  logic [15:0] w,
  input  logic        prev_d,
  output logic [7:0]  data,
  output logic        is_sync,
  output logic        clk_bad
);

  logic [7:0] clks;
  logic [7:0] dprev;
  logic [7:0] exp_clk;

  // Split the window into interleaved clock/data cells (odd = clock, even = data).
  always_comb begin
    data = 8'h00;
    clks = 8'h00;
    for (int i = 0; i < 8; i++) begin
      data[i] = w[2*i];
      clks[i] = w[2*i+1];
    end
  end

  // Each clock cell is 1 only when both neighbouring data bits are 0; bit 7
  // borrows its left neighbour from the last data bit of the previous byte.
  assign dprev   = {prev_d, data[7:1]};
  assign exp_clk = ~(dprev | data);
  assign is_sync = (w == SYNC_WORD);

  // The sync mark breaks the clock rule on purpose, so it is never flagged.
  assign clk_bad = ~is_sync & (|(clks ^ exp_clk));

endmodule

// File: rtl/mfm_decoder.sv
// MFM cell-stream decoder: hunts for the A1 sync mark, then frames aligned
// 16-cell windows into bytes and flags clock-rule violations per byte.
module mfm_decoder
  import mfm_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int          MAX_ERRS  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cell_en,
  input  logic       si,
  input  logic       hunt,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       byte_mark,
  output logic       clk_err,
  output logic       locked
);

  localparam int EW = $clog2(MAX_ERRS + 1);

  state_t        state;
  state_t        state_nx;
  logic [15:0]   w;
  logic [15:0]   w_nx;
  logic [3:0]    cnt;
  logic [EW-1:0] errs;
  logic          errs_full;
  logic          prev_d;
  logic          vld_p0;

  logic [7:0]    data;
  logic          is_sync;
  logic          clk_bad;

  assign w_nx      = {w[14:0], si};
  assign errs_full = (errs == EW'(MAX_ERRS));
  assign locked    = (state == LOCKED);

  mfm_clock_check #(
    .SYNC_WORD (SYNC_WORD)
  ) u_chk (
    .w       (w),
    .prev_d  (prev_d),
    .data    (data),
    .is_sync (is_sync),
    .clk_bad (clk_bad)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HUNT;
    end else begin
      state <= state_nx;
    end
  end

  // Next state: lock on an emitted sync mark, fall back on request or when
  // the error budget is used up (one clock after the byte that used it up).
  always_comb begin
    state_nx = state;
    case (state)
      HUNT: begin
        if (!hunt && vld_p0) state_nx = LOCKED;
      end
      LOCKED: begin
        if (hunt || errs_full) state_nx = HUNT;
      end
      default: state_nx = HUNT;
    endcase
  end

  // Stage p0: shift cells in, count them and flag a completed window.
  // Stage p1: the flagged window is decoded and emitted as a byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w          <= 16'h0000;
      cnt        <= 4'd0;
      errs       <= '0;
      prev_d     <= 1'b0;
      vld_p0     <= 1'b0;
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      byte_mark  <= 1'b0;
      clk_err    <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      byte_mark  <= 1'b0;
      clk_err    <= 1'b0;
      vld_p0     <= 1'b0;
      if (cell_en) w <= w_nx;
      if (hunt) begin
        cnt <= 4'd0;
      end else if (vld_p0) begin
        byte_valid <= 1'b1;
        prev_d     <= w[0];
        if (state == HUNT) begin
          byte_out  <= MARK_BYTE;
          byte_mark <= 1'b1;
          errs      <= '0;
          cnt       <= 4'd0;
        end else begin
          byte_out  <= data;
          byte_mark <= is_sync;
          clk_err   <= clk_bad;
          if (clk_bad && !errs_full) errs <= errs + EW'(1);
        end
      end else if (state == LOCKED && errs_full) begin
        cnt <= 4'd0;
      end else if (cell_en) begin
        if (state == LOCKED) begin
          cnt    <= cnt + 4'd1;
          vld_p0 <= (cnt == 4'd15);
        end else begin
          vld_p0 <= (w_nx == SYNC_WORD);
        end
      end
    end
  end

endmodule

// File: tb/tb_mfm_decoder.sv
// Directed + randomized bench for mfm_decoder with a word-level reference model.
module tb_mfm_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       cell_en;
  logic       si;
  logic       hunt;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_mark;
  logic       clk_err;
  logic       locked;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ce_cyc = 0;
  int bv_cyc = 0;

  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];

  bit m_locked;
  bit m_prev;
  int m_errs;

  mfm_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .cell_en    (cell_en),
    .si         (si),
    .hunt       (hunt),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_mark  (byte_mark),
    .clk_err    (clk_err),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (byte_valid) begin
      got_q.push_back({byte_mark, clk_err, byte_out});
      bv_cyc = cyc;
    end
  end

  // MFM encoder: clock cell is 1 only between two 0 data bits.
  function automatic logic [15:0] enc(input logic [7:0] d, input logic p);
    logic [15:0] r;
    logic        q;
    r = 16'h0000;
    q = p;
    for (int i = 7; i >= 0; i--) begin
      r = {r[13:0], ~(q | d[i]), d[i]};
      q = d[i];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word-level reference: a byte is valid MFM iff re-encoding its data reproduces it.
  task automatic model_word(input logic [15:0] w);
    logic [7:0] d;
    bit mark;
    bit err;
    for (int i = 0; i < 8; i++) d[i] = w[2*i];
    if (!m_locked) begin
      if (w == 16'h4489) begin
        exp_q.push_back({1'b1, 1'b0, 8'hA1});
        m_locked = 1;
        m_errs   = 0;
        m_prev   = w[0];
      end
    end else begin
      mark = (w == 16'h4489);
      err  = !mark && (enc(d, m_prev) != w);
      exp_q.push_back({mark, err, d});
      m_prev = w[0];
      if (err && m_errs < 4) m_errs++;
      if (m_errs == 4) m_locked = 0;
    end
  endtask

  task automatic send_cell(input logic b, input int gap);
    @(negedge clk);
    cell_en = 1'b1;
    si      = b;
    ce_cyc  = cyc;
    @(negedge clk);
    cell_en = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_cell(w[i], $urandom_range(0, 3));
    model_word(w);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_locked = 0;
    m_prev   = 0;
    m_errs   = 0;
  endtask

  task automatic check_events(input string tag);
    int n;
    repeat (5) @(negedge clk);
    check($sformatf("%s_count", tag), got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [15:0] w;
    logic [7:0]  b;
    int          nflip;

    reset   = 1'b1;
    cell_en = 1'b0;
    si      = 1'b0;
    hunt    = 1'b0;
    m_locked = 0;
    m_prev   = 0;
    m_errs   = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle after reset: everything quiet.
    repeat (20) @(negedge clk);
    check("idle_valid", byte_valid, 1'b0);
    check("idle_mark", byte_mark, 1'b0);
    check("idle_err", clk_err, 1'b0);
    check("idle_locked", locked, 1'b0);
    check("idle_byte", byte_out, 8'h00);
    check("idle_events", got_q.size(), 0);

    // Sync then 5555 -> A1 mark, then FF.
    send_word(16'h4489);
    repeat (3) @(negedge clk);
    check("sync_latency", bv_cyc - ce_cyc, 2);
    check("sync_locked", locked, 1'b1);
    send_word(16'h5555);
    check_events("a1_ff");

    // Three back-to-back marks followed by an encoded FE.
    do_reset();
    send_word(16'h4489);
    send_word(16'h4489);
    send_word(16'h4489);
    send_word(enc(8'hFE, m_prev));
    check_events("a1x3_fe");

    // Four clock-rule violations drop lock; the next byte is ignored.
    send_word(16'h0000);
    send_word(16'h0000);
    send_word(16'h0000);
    send_word(16'h0000);
    check_events("zeros");
    check("zeros_unlocked", locked, 1'b0);
    send_word(16'hAAAA);
    check_events("no_sync");
    check("no_sync_locked", locked, 1'b0);

    // hunt on the clock a byte completes suppresses that byte.
    send_word(16'h4489);
    check_events("resync");
    w = enc(8'h3C, m_prev);
    for (int i = 15; i >= 1; i--) send_cell(w[i], $urandom_range(0, 3));
    @(negedge clk);
    cell_en = 1'b1;
    si      = w[0];
    @(negedge clk);
    cell_en = 1'b0;
    hunt    = 1'b1;
    @(negedge clk);
    hunt = 1'b0;
    m_locked = 0;
    check_events("hunt");
    check("hunt_locked", locked, 1'b0);

    // Reset after 9 cells of a byte, then re-sync cleanly.
    send_word(16'h4489);
    check_events("pre_reset");
    w = enc(8'hC3, m_prev);
    for (int i = 15; i >= 7; i--) send_cell(w[i], 1);
    do_reset();
    check("rst_locked", locked, 1'b0);
    check("rst_byte", byte_out, 8'h00);
    send_word(16'h4489);
    send_word(enc(8'h5A, m_prev));
    check_events("post_reset");

    // Random bytes with random cell gaps and a few corrupted clock cells.
    do_reset();
    nflip = 0;
    send_word(16'h4489);
    for (int k = 0; k < 30; k++) begin
      b = 8'($urandom);
      w = enc(b, m_prev);
      if (nflip < 3 && $urandom_range(0, 7) == 0) begin
        w = w ^ (16'h8000 >> (2 * $urandom_range(0, 7)));
        nflip++;
      end
      send_word(w);
    end
    check_events("rand");
    check("rand_locked", locked, m_locked);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
